// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the narrow-to-wide bit gearbox.
package gearbox_pkg;
  localparam int DEF_IN_W  = 5;
  localparam int DEF_OUT_W = 16;

  // One chunk can land only while cnt < OUT_W, so the top bit sits at OUT_W+IN_W-2.
  function automatic int acc_w(input int in_w, input int out_w);
    return out_w + in_w - 1;
  endfunction

  typedef logic [$clog2(DEF_OUT_W+DEF_IN_W)-1:0] cnt_t;
endpackage

// File: rtl/gearbox_acc.sv
// Accumulator datapath: LSB-first chunk insert and word-wide shift-out.
module gearbox_acc
  import gearbox_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = $clog2(OUT_W+IN_W),
  parameter int AW    = acc_w(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_fire,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic             i_out_fire,
  output logic [OUT_W-1:0] o_word,
  output logic [CNT_W-1:0] o_cnt
);
  localparam logic [CNT_W-1:0] C_IN  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] C_OUT = CNT_W'(OUT_W);

  logic [AW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    w_ins;

  // Bits at index >= cnt are always zero, so an OR places the chunk exactly.
  assign w_ins = AW'(i_in_data) << r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_in_fire) begin
      r_acc <= r_acc | w_ins;
      r_cnt <= r_cnt + C_IN;
    end else if (i_out_fire) begin
      r_acc <= r_acc >> OUT_W;
      r_cnt <= (r_cnt >= C_OUT) ? r_cnt - C_OUT : '0;
    end
  end

  assign o_word = r_acc[OUT_W-1:0] & ~({OUT_W{1'b1}} << r_cnt);
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/bit_gearbox_unpacker.sv
// Narrow-to-wide bit gearbox: handshake and flush control around gearbox_acc.
module bit_gearbox_unpacker
  import gearbox_pkg::*;
#(
  parameter  int IN_W  = DEF_IN_W,
  parameter  int OUT_W = DEF_OUT_W,
  localparam int CNT_W = $clog2(OUT_W+IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_bits,
  output logic             out_last,
  input  logic             flush_req,
  output logic             flush_done
);
  localparam logic [CNT_W-1:0] C_OUT = CNT_W'(OUT_W);

  logic             r_pend, r_done;
  logic [CNT_W-1:0] w_cnt;
  logic [OUT_W-1:0] w_word;
  logic             w_in_rdy, w_out_vld, w_in_fire, w_out_fire, w_drained;

  gearbox_acc #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .i_in_fire  (w_in_fire),
    .i_in_data  (in_data),
    .i_out_fire (w_out_fire),
    .o_word     (w_word),
    .o_cnt      (w_cnt)
  );

  // in_ready and out_valid are disjoint, so the accumulator never inserts and shifts together.
  assign w_in_rdy   = (w_cnt < C_OUT) && !r_pend;
  assign w_out_vld  = (w_cnt >= C_OUT) || (r_pend && (w_cnt != '0));
  assign w_in_fire  = in_valid && w_in_rdy;
  assign w_out_fire = w_out_vld && out_ready;
  assign w_drained  = r_pend && ((w_cnt == '0) || (w_out_fire && (w_cnt <= C_OUT)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_drained;
      if (r_pend) begin
        if (w_drained) r_pend <= 1'b0;
      end else if (flush_req) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_rdy;
  assign out_valid  = w_out_vld;
  assign out_data   = w_word;
  assign out_bits   = (w_cnt >= C_OUT) ? C_OUT : w_cnt;
  assign out_last   = r_pend && w_out_vld && (w_cnt <= C_OUT);
  assign flush_done = r_done;
endmodule
